// File: rtl/mmio_init_pkg.sv
// mmio_init_pkg: shared types and constants for the CCI-P MMIO initiator.
// Holds the FSM state enum, bus widths and the standard DFH register map.
package mmio_init_pkg;

    localparam int ADDR_W = 16;
    localparam int TID_W  = 9;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } t_mmio_init_state;

    // Standard device feature header registers (dword addresses)
    localparam logic [ADDR_W-1:0] ADDR_DFH      = 16'h0000;
    localparam logic [ADDR_W-1:0] ADDR_AFU_ID_L = 16'h0002;
    localparam logic [ADDR_W-1:0] ADDR_AFU_ID_H = 16'h0004;
    localparam logic [ADDR_W-1:0] ADDR_RSVD0    = 16'h0006;
    localparam logic [ADDR_W-1:0] ADDR_RSVD1    = 16'h0008;
    localparam logic [ADDR_W-1:0] ADDR_USER_REG = 16'h0020;

    // TID advance; the 9-bit width gives the 511 -> 0 wrap for free
    function automatic logic [TID_W-1:0] next_tid(input logic [TID_W-1:0] tid);
        return tid + TID_W'(1);
    endfunction

endpackage

// File: rtl/mmio_initiator_if.sv
// mmio_initiator_if: command/response port plus the CCI-P MMIO request and
// read-response signals of the initiator. "master" is the initiator side,
// "slave" is the side that issues commands and models the AFU.
interface mmio_initiator_if;
    import mmio_init_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    logic              req_wr_valid;
    logic              req_rd_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [TID_W-1:0]  req_tid;
    logic [DATA_W-1:0] req_data;

    logic              rd_rsp_valid;
    logic [TID_W-1:0]  rd_rsp_tid;
    logic [DATA_W-1:0] rd_rsp_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        output req_wr_valid, req_rd_valid, req_addr, req_tid, req_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        output rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  req_wr_valid, req_rd_valid, req_addr, req_tid, req_data
    );

endinterface

// File: rtl/mmio_init_timer.sv
// mmio_init_timer: 16-bit read-response watchdog. load_i clears the count,
// count_i advances it, expire_o flags the last allowed counting cycle.
module mmio_init_timer #(
    parameter int LIMIT = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt_q, cnt_d;

    // next count: clear on load, otherwise advance while counting
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/mmio_initiator.sv
// mmio_initiator: single-outstanding CCI-P MMIO initiator. Takes one
// read/write command, pulses the matching MMIO request, matches the read
// response by TID and returns a one-cycle completion strobe.
// Optional feature: define MMIO_INIT_TIMEOUT_EN to bound the read wait by
// TIMEOUT_CYCLES and report expiry on rsp_err.
module mmio_initiator
    import mmio_init_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic               clk,
    input  logic               rst,
    mmio_initiator_if.master   bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mmio_initiator: TIMEOUT_CYCLES must be within 2..65535");
    end

    t_mmio_init_state  state_q, state_d;
    logic              wr_q, wr_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              req_wr_valid_q, req_wr_valid_d;
    logic              req_rd_valid_q, req_rd_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_match;
    logic              timeout_hit;

    assign rsp_match = bus.rd_rsp_valid && (bus.rd_rsp_tid == tid_q);

`ifdef MMIO_INIT_TIMEOUT_EN
    logic tmr_load;
    logic tmr_count;

    assign tmr_load  = (state_q == ST_ISSUE) && !wr_q;
    assign tmr_count = (state_q == ST_WAIT_RD);

    mmio_init_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .count_i  (tmr_count),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // next state, latched command, TID advance and next registered outputs
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        tid_d      = tid_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    wr_d       = bus.cmd_write;
                    req_addr_d = bus.cmd_addr;
                    req_data_d = bus.cmd_data;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = wr_q ? ST_DONE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                // a matching response in the last counting cycle beats expiry
                if (rsp_match) begin
                    rsp_data_d = bus.rd_rsp_data;
                    state_d    = ST_DONE;
                end else if (timeout_hit) begin
                    rsp_err_d  = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!wr_q) begin
                    tid_d = next_tid(tid_q);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_wr_valid_d = (state_d == ST_ISSUE) && wr_d;
        req_rd_valid_d = (state_d == ST_ISSUE) && !wr_d;
        rsp_valid_d    = (state_d == ST_DONE);
        cmd_ready_d    = (state_d == ST_IDLE);
        busy_d         = (state_d != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // command, TID and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q           <= 1'b0;
            tid_q          <= '0;
            req_addr_q     <= '0;
            req_data_q     <= '0;
            req_wr_valid_q <= 1'b0;
            req_rd_valid_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            wr_q           <= wr_d;
            tid_q          <= tid_d;
            req_addr_q     <= req_addr_d;
            req_data_q     <= req_data_d;
            req_wr_valid_q <= req_wr_valid_d;
            req_rd_valid_q <= req_rd_valid_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.busy         = busy_q;
    assign bus.req_wr_valid = req_wr_valid_q;
    assign bus.req_rd_valid = req_rd_valid_q;
    assign bus.req_addr     = req_addr_q;
    assign bus.req_tid      = tid_q;
    assign bus.req_data     = req_data_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// tb_mmio_initiator: directed bench for mmio_initiator. Inputs change and
// outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mmio_initiator;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [8:0] cur_tid;

    mmio_initiator_if bus_if ();

    mmio_initiator #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // offer one command; returns in the request-pulse cycle (T+1)
    task automatic issue(input logic wr, input logic [15:0] a, input logic [63:0] d);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = a;
        bus_if.cmd_data  = d;
        step();
        bus_if.cmd_valid = 1'b0;
    endtask

    // read answered one cycle after the request with the expected TID
    task automatic read_echo(input logic [15:0] a, input logic [63:0] d, input logic [8:0] tid);
        issue(1'b0, a, d ^ 64'hFFFF);
        chk("rd_pulse", {63'd0, bus_if.req_rd_valid}, 64'd1);
        chk("rd_tid", {55'd0, bus_if.req_tid}, {55'd0, tid});
        step();
        bus_if.rd_rsp_valid = 1'b1;
        bus_if.rd_rsp_tid   = tid;
        bus_if.rd_rsp_data  = d;
        step();
        bus_if.rd_rsp_valid = 1'b0;
        chk("rd_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd1);
        chk("rd_rsp_data", bus_if.rsp_data, d);
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cur_tid = 9'd0;
        rst = 1'b1;
        bus_if.cmd_valid    = 1'b0;
        bus_if.cmd_write    = 1'b0;
        bus_if.cmd_addr     = 16'h0;
        bus_if.cmd_data     = 64'h0;
        bus_if.rd_rsp_valid = 1'b0;
        bus_if.rd_rsp_tid   = 9'h0;
        bus_if.rd_rsp_data  = 64'h0;
        step();
        step();

        // reset state
        chk("rst_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("rst_req_valid", {62'd0, bus_if.req_wr_valid, bus_if.req_rd_valid}, 64'd0);
        chk("rst_req_addr", {48'd0, bus_if.req_addr}, 64'd0);
        chk("rst_req_tid", {55'd0, bus_if.req_tid}, 64'd0);
        chk("rst_req_data", bus_if.req_data, 64'd0);
        chk("rst_rsp", {62'd0, bus_if.rsp_valid, bus_if.rsp_err}, 64'd0);
        chk("rst_rsp_data", bus_if.rsp_data, 64'd0);
        rst = 1'b0;
        step();

        // write to the user register
        issue(1'b1, 16'h0020, 64'hDEAD_BEEF_CAFE_F00D);
        chk("wr_pulse", {62'd0, bus_if.req_wr_valid, bus_if.req_rd_valid}, 64'd2);
        chk("wr_addr", {48'd0, bus_if.req_addr}, 64'h0020);
        chk("wr_data", bus_if.req_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("wr_busy", {62'd0, bus_if.busy, bus_if.cmd_ready}, 64'd2);
        step();
        chk("wr_pulse_end", {62'd0, bus_if.req_wr_valid, bus_if.req_rd_valid}, 64'd0);
        chk("wr_rsp", {62'd0, bus_if.rsp_valid, bus_if.rsp_err}, 64'd2);
        chk("wr_rsp_data", bus_if.rsp_data, 64'd0);
        chk("wr_cmd_ready_lo", {63'd0, bus_if.cmd_ready}, 64'd0);
        step();
        chk("wr_rsp_end", {63'd0, bus_if.rsp_valid}, 64'd0);
        chk("wr_cmd_ready_hi", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("wr_tid_kept", {55'd0, bus_if.req_tid}, 64'd0);
        chk("wr_addr_held", {48'd0, bus_if.req_addr}, 64'h0020);

        // read DFH, answered one cycle after the request
        issue(1'b0, 16'h0000, 64'h0);
        chk("dfh_pulse", {62'd0, bus_if.req_wr_valid, bus_if.req_rd_valid}, 64'd1);
        chk("dfh_tid", {55'd0, bus_if.req_tid}, 64'd0);
        chk("dfh_addr", {48'd0, bus_if.req_addr}, 64'h0000);
        step();
        chk("dfh_pulse_end", {63'd0, bus_if.req_rd_valid}, 64'd0);
        bus_if.rd_rsp_valid = 1'b1;
        bus_if.rd_rsp_tid   = 9'd0;
        bus_if.rd_rsp_data  = 64'h1000_0100_0000_0000;
        step();
        bus_if.rd_rsp_valid = 1'b0;
        chk("dfh_rsp", {62'd0, bus_if.rsp_valid, bus_if.rsp_err}, 64'd2);
        chk("dfh_rsp_data", bus_if.rsp_data, 64'h1000_0100_0000_0000);
        step();
        chk("dfh_ready", {62'd0, bus_if.rsp_valid, bus_if.cmd_ready}, 64'd1);
        chk("dfh_next_tid", {55'd0, bus_if.req_tid}, 64'd1);
        chk("dfh_rsp_data_clr", bus_if.rsp_data, 64'd0);

        // bring the TID to 3
        read_echo(16'h0002, 64'h0123_4567_89AB_CDEF, 9'd1);
        read_echo(16'h0004, 64'hFEDC_BA98_7654_3210, 9'd2);

        // ISSUE-cycle and wrong-TID responses are ignored
        issue(1'b0, 16'h0020, 64'h0);
        chk("tid3_req", {55'd0, bus_if.req_tid}, 64'd3);
        bus_if.rd_rsp_valid = 1'b1;
        bus_if.rd_rsp_tid   = 9'd3;
        bus_if.rd_rsp_data  = 64'h9999;
        step();
        bus_if.rd_rsp_tid   = 9'd2;
        bus_if.rd_rsp_data  = 64'h1111;
        chk("issue_rsp_ignored", {63'd0, bus_if.rsp_valid}, 64'd0);
        step();
        bus_if.rd_rsp_tid   = 9'd3;
        bus_if.rd_rsp_data  = 64'h2222;
        chk("stale_tid_ignored", {63'd0, bus_if.rsp_valid}, 64'd0);
        step();
        bus_if.rd_rsp_valid = 1'b0;
        chk("tid3_rsp", {63'd0, bus_if.rsp_valid}, 64'd1);
        chk("tid3_data", bus_if.rsp_data, 64'h2222);
        step();
        chk("tid3_single", {62'd0, bus_if.rsp_valid, bus_if.cmd_ready}, 64'd1);
        cur_tid = 9'd4;

        // response while idle is ignored
        bus_if.rd_rsp_valid = 1'b1;
        bus_if.rd_rsp_tid   = 9'd4;
        bus_if.rd_rsp_data  = 64'h5555;
        step();
        bus_if.rd_rsp_valid = 1'b0;
        step();
        chk("idle_rsp_ignored", {62'd0, bus_if.rsp_valid, bus_if.busy}, 64'd0);
        chk("idle_tid_kept", {55'd0, bus_if.req_tid}, {55'd0, cur_tid});

`ifdef MMIO_INIT_TIMEOUT_EN
        // no response: expiry 17 cycles after ISSUE
        issue(1'b0, 16'h0006, 64'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("tmo_wait", {63'd0, bus_if.rsp_valid}, 64'd0);
        end
        step();
        chk("tmo_rsp", {62'd0, bus_if.rsp_valid, bus_if.rsp_err}, 64'd3);
        chk("tmo_data", bus_if.rsp_data, 64'd0);
        bus_if.rd_rsp_valid = 1'b1;
        bus_if.rd_rsp_tid   = cur_tid;
        bus_if.rd_rsp_data  = 64'h7777;
        step();
        bus_if.rd_rsp_valid = 1'b0;
        step();
        chk("tmo_late_ignored", {62'd0, bus_if.rsp_valid, bus_if.rsp_err}, 64'd0);
        cur_tid = cur_tid + 9'd1;
        read_echo(16'h0008, 64'hABCD, cur_tid);
        cur_tid = cur_tid + 9'd1;
`endif

        // reset during WAIT_RD, pending response delivered afterwards
        issue(1'b0, 16'h0020, 64'h0);
        step();
        rst = 1'b1;
        bus_if.rd_rsp_valid = 1'b1;
        bus_if.rd_rsp_tid   = cur_tid;
        bus_if.rd_rsp_data  = 64'h4444;
        step();
        chk("mid_rst_ready", {62'd0, bus_if.cmd_ready, bus_if.busy}, 64'd2);
        chk("mid_rst_req", {62'd0, bus_if.req_wr_valid, bus_if.req_rd_valid}, 64'd0);
        chk("mid_rst_tid", {55'd0, bus_if.req_tid}, 64'd0);
        chk("mid_rst_addr", {48'd0, bus_if.req_addr}, 64'd0);
        rst = 1'b0;
        step();
        bus_if.rd_rsp_valid = 1'b0;
        chk("mid_rst_no_rsp", {62'd0, bus_if.rsp_valid, bus_if.rsp_err}, 64'd0);
        chk("mid_rst_rsp_data", bus_if.rsp_data, 64'd0);
        step();
        chk("mid_rst_idle", {63'd0, bus_if.cmd_ready}, 64'd1);

        // 512 reads walk the TID 0..511, the 513th wraps to 0
        for (int i = 0; i < 512; i++) begin
            read_echo(16'h0020, {32'hA5A5_0000, 23'd0, 9'(i)}, 9'(i));
        end
        read_echo(16'h0020, 64'h0BAD_F00D, 9'd0);
        chk("wrap_next_tid", {55'd0, bus_if.req_tid}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
